// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU command sequencer.
// FSM state encoding and ALU opcode values, also used by the ALU and the benches.
package uart_alu_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_RX_A    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RX_B    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RX_OP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC    = 3'd3;
    localparam logic [STATE_W-1:0] ST_TX_LOAD = 3'd4;
    localparam logic [STATE_W-1:0] ST_TX_WAIT = 3'd5;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/inactivity_timer.sv
// Inactivity timer: counts enabled clocks since the last clear and flags the
// cycle on which the count would reach TIMEOUT_CLKS. TIMEOUT_CLKS=0 disables it.
// Ports: clk, reset (sync, active-high), clear, enable, expire_c (combinational).
module inactivity_timer #(
    parameter logic [15:0] TIMEOUT_CLKS = 16'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [15:0] count_q;

    // Clear wins over expiry, so a byte arriving on the final cycle is kept.
    assign expire_c = (TIMEOUT_CLKS != 16'd0) && enable && !clear &&
                      (count_q == TIMEOUT_CLKS - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || !enable || expire_c) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Command sequencer between the UART and the ALU: assembles operand A, operand B
// (NBYTES each, little-endian) and an opcode byte from RX, runs the ALU for one
// cycle, then returns the result one byte per TX handshake.
// Ports: i_clock/i_reset; RX byte stream (i_rx_data, i_rx_done); ALU operands
// (o_alu_a, o_alu_b, o_alu_op) and result (i_alu_result); TX byte handshake
// (o_tx_data, o_tx_start, i_tx_done); status o_busy and o_timeout.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NB_OP        = 6,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [NB_OP-1:0]      o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || NB_OP > 8 || NB_OP < 1) begin : g_param_check
        $error("uart_alu_sequencer: DATA_WIDTH must be a multiple of 8 and NB_OP in 1..8");
    end

    logic [STATE_W-1:0]    state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [NB_OP-1:0]      op_q, op_d;
    logic [7:0]            txd_q, txd_d;
    logic                  txs_d, busy_d, tmo_d;
    logic                  rx_state, timer_en, timer_expire_c;

    // Timer only runs while a frame is partially received.
    assign rx_state = (state_q == ST_RX_A) || (state_q == ST_RX_B) || (state_q == ST_RX_OP);
    assign timer_en = rx_state && !((state_q == ST_RX_A) && (idx_q == '0));

    inactivity_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk      (i_clock),
        .reset    (i_reset),
        .clear    (i_rx_done),
        .enable   (timer_en),
        .expire_c (timer_expire_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        txd_d   = txd_q;
        txs_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            ST_RX_A, ST_RX_B: begin
                if (i_rx_done) begin
                    for (int unsigned k = 0; k < NBYTES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            if (state_q == ST_RX_A) a_d[k*8 +: 8] = i_rx_data;
                            else                    b_d[k*8 +: 8] = i_rx_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_RX_OP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timer_expire_c) begin
                    state_d = ST_RX_A;
                    idx_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            ST_RX_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = ST_EXEC;
                end else if (timer_expire_c) begin
                    state_d = ST_RX_A;
                    idx_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            ST_EXEC: begin
                res_d   = i_alu_result;
                idx_d   = '0;
                state_d = ST_TX_LOAD;
            end
            ST_TX_LOAD: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RX_A;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_TX_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_RX_A;
                idx_d   = '0;
            end
        endcase

        // TX byte is loaded on entry to TX_LOAD and held until the next load.
        if (state_d == ST_TX_LOAD) begin
            txs_d = 1'b1;
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (idx_d == IDX_W'(k)) txd_d = res_d[k*8 +: 8];
            end
        end

        busy_d = (state_d == ST_EXEC) || (state_d == ST_TX_LOAD) || (state_d == ST_TX_WAIT);
    end

    // State and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_RX_A;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            txd_q      <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            txd_q      <= txd_d;
            o_tx_start <= txs_d;
            o_busy     <= busy_d;
            o_timeout  <= tmo_d;
        end
    end

    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_op  = op_q;
    assign o_tx_data = txd_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: a 16-bit instance with a 100-clock timeout and
// an 8-bit instance without timeout, sharing one RX/TX stimulus path.
module tb_uart_alu_sequencer;
    import uart_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done, tx_done;
    logic       sel8;

    logic [15:0] a16, b16, res16;
    logic [5:0]  op16;
    logic [7:0]  txd16;
    logic        txs16, busy16, tmo16;

    logic [7:0]  a8, b8, res8;
    logic [5:0]  op8;
    logic [7:0]  txd8;
    logic        txs8, busy8, tmo8;

    // Reference ALU feeding the DUTs.
    function automatic logic [15:0] alu(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return 16'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 16'h0000;
        endcase
    endfunction

    assign res16 = alu(op16, a16, b16);
    assign res8  = 8'(alu(op8, {{8{a8[7]}}, a8}, {8'h00, b8}));

    uart_alu_sequencer #(.DATA_WIDTH(16), .NB_OP(6), .TIMEOUT_CLKS(16'd100)) dut16 (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done & ~sel8),
        .o_alu_a(a16), .o_alu_b(b16), .o_alu_op(op16), .i_alu_result(res16),
        .o_tx_data(txd16), .o_tx_start(txs16), .i_tx_done(tx_done & ~sel8),
        .o_busy(busy16), .o_timeout(tmo16)
    );

    uart_alu_sequencer #(.DATA_WIDTH(8), .NB_OP(6), .TIMEOUT_CLKS(16'd0)) dut8 (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done & sel8),
        .o_alu_a(a8), .o_alu_b(b8), .o_alu_op(op8), .i_alu_result(res8),
        .o_tx_data(txd8), .o_tx_start(txs8), .i_tx_done(tx_done & sel8),
        .o_busy(busy8), .o_timeout(tmo8)
    );

    // Selected-DUT view.
    wire [15:0] a_s    = sel8 ? {8'h00, a8} : a16;
    wire [15:0] b_s    = sel8 ? {8'h00, b8} : b16;
    wire [5:0]  op_s   = sel8 ? op8 : op16;
    wire [7:0]  txd_s  = sel8 ? txd8 : txd16;
    wire        txs_s  = sel8 ? txs8 : txs16;
    wire        busy_s = sel8 ? busy8 : busy16;

    int total = 0;
    int bad   = 0;
    int tmo_pulses = 0;
    logic [7:0] sb[$];

    always @(negedge clk) if (tmo16) tmo_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Called one cycle after the opcode byte; checks EXEC, then serves all TX bytes.
    task automatic finish_frame(input logic [15:0] ea, input logic [15:0] eb, input logic [5:0] eop,
                                input logic [15:0] eres, input bit inject);
        int nb = sel8 ? 1 : 2;
        logic [7:0] exp_b;
        int n;
        for (int k = 0; k < nb; k++) sb.push_back(eres[k*8 +: 8]);
        check("exec_busy", 32'(busy_s), 32'd1);
        check("alu_a", 32'(a_s), 32'(ea));
        check("alu_b", 32'(b_s), 32'(eb));
        check("alu_op", 32'(op_s), 32'(eop));
        tick();
        check("first_start_latency", 32'(txs_s), 32'd1);
        for (int k = 0; k < nb; k++) begin
            n = 0;
            while (!txs_s && n < 10) begin
                tick();
                n++;
            end
            check("tx_start_seen", 32'(txs_s), 32'd1);
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
                exp_b = 8'hxx;
            end else begin
                exp_b = sb.pop_front();
            end
            check("tx_byte", 32'(txd_s), 32'(exp_b));
            tick();
            check("tx_start_one_cycle", 32'(txs_s), 32'd0);
            if (inject && k == 0) send_byte(8'hAA);
            else tick();
            tick();
            check("tx_byte_held", 32'(txd_s), 32'(exp_b));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        check("idle_after_tx", 32'(busy_s), 32'd0);
        check("alu_a_kept", 32'(a_s), 32'(ea));
        check("alu_b_kept", 32'(b_s), 32'(eb));
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                             input logic [5:0] eop, input logic [15:0] eres, input bit inject);
        int nb = sel8 ? 1 : 2;
        for (int k = 0; k < nb; k++) send_byte(a[k*8 +: 8]);
        for (int k = 0; k < nb; k++) send_byte(b[k*8 +: 8]);
        send_byte(opb);
        finish_frame(a, b, eop, eres, inject);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op_byte;
        logic [5:0]  op;
        logic [15:0] res;
        bit          inject;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int p0;
        bit saw_start;

        vecs[0] = '{16'h1234, 16'h0011, 8'h20, 6'h20, 16'h1245, 1'b0};
        vecs[1] = '{16'h0001, 16'h0002, 8'h20, 6'h20, 16'h0003, 1'b0};
        vecs[2] = '{16'hF0F0, 16'h0FF0, 8'h24, 6'h24, 16'h00F0, 1'b0};
        vecs[3] = '{16'h1234, 16'h00FF, 8'h26, 6'h26, 16'h12CB, 1'b1};
        vecs[4] = '{16'h8000, 16'h0004, 8'h03, 6'h03, 16'hF800, 1'b0};
        vecs[5] = '{16'h0010, 16'h0001, 8'hE2, 6'h22, 16'h000F, 1'b0};

        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0; sel8 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_a", 32'(a16), 32'd0);
        check("rst_b", 32'(b16), 32'd0);
        check("rst_op", 32'(op16), 32'd0);
        check("rst_txd", 32'(txd16), 32'd0);
        check("rst_outs16", {29'd0, txs16, busy16, tmo16}, 32'd0);
        check("rst_outs8", {8'd0, a8, b8, 2'd0, op8}, 32'd0);

        // Table-driven frames on the 16-bit instance.
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op_byte, vecs[i].op, vecs[i].res, vecs[i].inject);

        // Timeout: one byte then silence discards the partial frame.
        repeat (3) tick();
        p0 = tmo_pulses;
        send_byte(8'h34);
        n = 1;
        while (!tmo16 && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycle", 32'(n), 32'd101);
        tick();
        check("timeout_one_cycle", 32'(tmo16), 32'd0);
        check("timeout_pulses", 32'(tmo_pulses - p0), 32'd1);
        run_frame(16'h0001, 16'h0002, 8'h20, 6'h20, 16'h0003, 1'b0);

        // Byte arriving on the final countdown cycle is accepted.
        p0 = tmo_pulses;
        send_byte(8'h34);
        repeat (99) tick();
        send_byte(8'h12);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        finish_frame(16'h1234, 16'h0001, 6'h20, 16'h1235, 1'b0);
        check("no_timeout_on_edge", 32'(tmo_pulses - p0), 32'd0);

        // Reset during TX_WAIT.
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        tick();
        check("pre_reset_start", 32'(txs16), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_tx_reset_a", 32'(a16), 32'd0);
        check("mid_tx_reset_outs", {8'd0, txd16, 13'd0, op16, txs16, busy16, tmo16}, 32'd0);
        rst = 1'b0;
        sb.delete();
        saw_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (txs16) saw_start = 1'b1;
        end
        check("no_start_after_reset", 32'(saw_start), 32'd0);
        run_frame(16'h0102, 16'h0304, 8'h25, 6'h25, 16'h0306, 1'b0);

        // 8-bit instance: NOR frame then an immediate second frame.
        sel8 = 1'b1;
        run_frame(16'h00F0, 16'h000F, 8'h27, 6'h27, 16'h0000, 1'b0);
        run_frame(16'h0003, 16'h0004, 8'h20, 6'h20, 16'h0007, 1'b0);
        sel8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Parametrised command sequencer between the UART receiver/transmitter and the ALU in the top-level datapath. It assembles multi-byte operands A and B plus an opcode byte from the RX byte stream and presents them to the ALU. It then captures the ALU result and serialises it back through the UART transmitter, one byte per TX handshake. It adds two things a fixed 8-bit interface lacks: configurable operand width and an inter-byte timeout that discards partial frames.

## Interface
- DATA_WIDTH, 8: operand/result width in bits; multiple of 8, ≥ 8; NBYTES = DATA_WIDTH/8
- NB_OP, 6: ALU opcode width, ≤ 8
- TIMEOUT_CLKS, 16'd0: idle clocks between RX bytes before a partial frame is discarded; 0 disables
- i_clock  in  1  single clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  8  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- o_alu_a  out  DATA_WIDTH  operand A, registered
- o_alu_b  out  DATA_WIDTH  operand B, registered
- o_alu_op  out  NB_OP  opcode, registered
- i_alu_result  in  DATA_WIDTH  combinational ALU result
- o_tx_data  out  8  byte for transmitter, held until i_tx_done
- o_tx_start  out  1  one-cycle pulse launching a TX byte
- i_tx_done  in  1  one-cycle pulse when TX byte finished
- o_busy  out  1  high in EXEC, TX_LOAD, TX_WAIT
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- Reset: all outputs 0; state RX_A; byte index 0; timeout counter 0.
- States: RX_A → RX_B → RX_OP → EXEC → TX_LOAD ⇄ TX_WAIT → RX_A.
- RX_A and RX_B: each i_rx_done shifts the byte into the operand, little-endian (byte k → bits 8k+7:8k). After NBYTES bytes, the state advances and the index clears.
- RX_OP: one byte; o_alu_op ← i_rx_data[NB_OP-1:0], upper bits ignored. Next state is EXEC.
- EXEC: one cycle; result register ← i_alu_result at the end of this cycle.
- TX_LOAD: o_tx_data ← result byte k (little-endian, k from 0); o_tx_start=1 for exactly this cycle. Next state is TX_WAIT.
- TX_WAIT: wait for i_tx_done. If k < NBYTES-1, set k++ and go to TX_LOAD; otherwise go to RX_A.
- Timeout: the counter runs only when a frame is partial (not RX_A with index 0) and a receive state is active. It clears on every i_rx_done. On reaching TIMEOUT_CLKS: state RX_A, index 0, o_timeout pulses. Operand and opcode registers keep their last values.
- i_rx_done while o_busy=1: byte dropped, no state change.
- i_tx_done outside TX_WAIT: ignored.

## Timing
- Opcode i_rx_done at cycle t: EXEC at t+1, first o_tx_start at t+2.
- After the final i_tx_done: RX_A on the next cycle, ready to accept a byte the cycle after.
- o_alu_a/b/op are stable from entry to EXEC until the next frame overwrites them.
- i_rx_done in the same cycle the counter would reach TIMEOUT_CLKS: the byte is accepted and no timeout occurs.
- i_reset has priority over everything, in any state including mid-TX. o_tx_start is never asserted in the reset cycle.

## Structure
- Package uart_alu_pkg: state encoding localparams, and opcode constants ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111 (shared with ALU and benches).
- Sub-module inactivity_timer (clear, enable, TIMEOUT_CLKS → expire pulse). Everything else lives in one FSM module.
- Elaboration check: DATA_WIDTH%8==0, NB_OP≤8.

## Test plan
- DATA_WIDTH=16. Bytes 34,12,11,00,20 with an ADD model → o_alu_a=1234, o_alu_b=0011, o_alu_op=20. TX sends 45 then 12, each o_tx_start waiting for i_tx_done.
- DATA_WIDTH=8. A=F0, B=0F, op=27 (NOR) → single TX byte 00; back in RX_A, and a second frame works immediately.
- TIMEOUT_CLKS=100. Send 34, then idle 100 clocks → o_timeout pulse, state RX_A. Then a full frame 01,00,02,00,20 → TX bytes 03,00.
- Byte on i_rx_done during TX_WAIT → ignored. Operands unchanged; the next frame is assembled from the following bytes only.
- Assert i_reset during TX_WAIT → next cycle all outputs 0, state RX_A. No further o_tx_start pulses.
- Opcode byte E2 with NB_OP=6 → o_alu_op=22 (SUB).
